// File: rtl/tri_fetch_ranged_if.sv
`default_nettype none
// ============================================================================
// Module   : tri_fetch_ranged_if
// Purpose  : Triangle stream bundle (valid/ready, vertex data, id, last flag)
// Revision : 1.0
// ============================================================================
interface tri_fetch_ranged_if #(
    parameter int COORD_WIDTH = 16,
    parameter int CW          = 12
);
    logic                                 valid_out;
    logic                                 ready_in;
    logic [2:0][2:0][COORD_WIDTH-1:0]     tri_vertices_out;
    logic [CW-1:0]                        tri_id_out;
    logic                                 last_tri_out;

    modport master (
        output valid_out,
        output tri_vertices_out,
        output tri_id_out,
        output last_tri_out,
        input  ready_in
    );

    modport slave (
        input  valid_out,
        input  tri_vertices_out,
        input  tri_id_out,
        input  last_tri_out,
        output ready_in
    );
endinterface
`default_nettype wire

// File: rtl/tri_fetch_ranged.sv
`default_nettype none
// ============================================================================
// Module   : tri_fetch_ranged
// Purpose  : Streams a (base, count) sub-range of the triangle ROM through a
//            credit-limited FIFO; one-shot or looping frames, pause and abort.
// Revision : 1.0
// ============================================================================
module tri_fetch_ranged #(
    parameter int    COORD_WIDTH = 16,
    parameter int    MAX_COUNT   = 2700,
    parameter int    FIFO_DEPTH  = 4,
    parameter int    ROM_LATENCY = 2,
    parameter int    PAUSE_WIDTH = 16,
    parameter string INIT_FILE   = "mesh.mem",
    localparam int   AW          = $clog2(MAX_COUNT),
    localparam int   CW          = $clog2(MAX_COUNT + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic [AW-1:0]          base_in,
    input  logic [CW-1:0]          count_in,
    input  logic                   loop_in,
    input  logic [PAUSE_WIDTH-1:0] pause_cycles_in,
    input  logic                   abort_in,
    tri_fetch_ranged_if.master     tri_if,
    output logic                   frame_done_out,
    output logic                   busy_out
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int FCW       = $clog2(FIFO_DEPTH + 1);
    localparam bit HAS_IMAGE = (INIT_FILE != "");

    typedef logic [2:0][2:0][COORD_WIDTH-1:0] tri_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    // Behavioural mesh image: coordinate k of vertex v at index a is a*9+v*3+k.
    function automatic tri_t rom_word(input logic [AW-1:0] addr);
        tri_t w;
        w = '0;
        if (HAS_IMAGE) begin
            for (int v = 0; v < 3; v++) begin
                for (int k = 0; k < 3; k++) begin
                    w[v][k] = COORD_WIDTH'(int'(addr) * 9 + v * 3 + k);
                end
            end
        end
        return w;
    endfunction

    state_t                 state_q, state_d;
    logic [AW-1:0]          base_q;
    logic [CW-1:0]          n_q;
    logic                   loop_q;
    logic [PAUSE_WIDTH-1:0] pause_q;
    logic [CW-1:0]          issued_q, issued_d;
    logic [PAUSE_WIDTH-1:0] pcnt_q, pcnt_d;

    logic [ROM_LATENCY-1:0] pipe_vld_q;
    logic [ROM_LATENCY-1:0] pipe_last_q;
    tri_t                   pipe_tri_q [ROM_LATENCY];
    logic [CW-1:0]          pipe_id_q  [ROM_LATENCY];

    tri_t                   fifo_tri [FIFO_DEPTH];
    logic [CW-1:0]          fifo_id  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [FCW-1:0]         fcnt_q;

    logic [CW-1:0]          w_room, w_n_eff;
    logic [AW-1:0]          w_addr;
    int                     w_inflight;
    logic                   w_credit, w_issue, w_push, w_pop, w_valid;
    logic                   w_drained, w_latch, w_done;

    always_comb begin
        w_room  = '0;
        w_n_eff = '0;
        if (int'(base_in) < MAX_COUNT) begin
            w_room  = CW'(MAX_COUNT - int'(base_in));
            w_n_eff = (count_in < w_room) ? count_in : w_room;
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + (pipe_vld_q[i] ? 1 : 0);
        end
    end

    // Credits count both in-flight reads and buffered entries, so a ROM
    // return always finds a free FIFO slot regardless of backpressure.
    assign w_credit  = (w_inflight + int'(fcnt_q)) < FIFO_DEPTH;
    assign w_issue   = (state_q == S_FETCH) && (issued_q != n_q) && w_credit && !abort_in;
    assign w_addr    = base_q + AW'(issued_q);
    assign w_push    = pipe_vld_q[ROM_LATENCY-1];
    assign w_valid   = (fcnt_q != '0);
    assign w_pop     = w_valid && tri_if.ready_in;
    assign w_drained = (fcnt_q == '0) && (w_inflight == 0);

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        pcnt_d   = pcnt_q;
        w_latch  = 1'b0;
        w_done   = 1'b0;
        if (w_issue) begin
            issued_d = issued_q + CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    w_latch  = 1'b1;
                    issued_d = '0;
                    state_d  = (w_n_eff == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (issued_d == n_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_done = 1'b1;
                    if (!loop_q) begin
                        state_d = S_IDLE;
                    end else if (pause_q <= PAUSE_WIDTH'(1)) begin
                        state_d  = S_FETCH;
                        issued_d = '0;
                    end else begin
                        // The done cycle is the first gap cycle, this PAUSE cycle the second.
                        state_d = S_PAUSE;
                        pcnt_d  = PAUSE_WIDTH'(2);
                    end
                end
            end
            S_PAUSE: begin
                if (pcnt_q >= pause_q) begin
                    state_d  = S_FETCH;
                    issued_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PAUSE_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_in) begin
            state_d  = S_IDLE;
            issued_d = '0;
            pcnt_d   = '0;
            w_latch  = 1'b0;
            w_done   = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            pcnt_q   <= '0;
            base_q   <= '0;
            n_q      <= '0;
            loop_q   <= 1'b0;
            pause_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            pcnt_q   <= pcnt_d;
            if (w_latch) begin
                base_q  <= base_in;
                n_q     <= w_n_eff;
                loop_q  <= loop_in;
                pause_q <= pause_cycles_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_tri_q[i] <= '0;
                pipe_id_q[i]  <= '0;
            end
        end else begin
            for (int i = ROM_LATENCY - 1; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
                pipe_tri_q[i]  <= pipe_tri_q[i-1];
                pipe_id_q[i]   <= pipe_id_q[i-1];
            end
            pipe_vld_q[0]  <= w_issue;
            pipe_last_q[0] <= (issued_q == n_q - CW'(1));
            pipe_tri_q[0]  <= rom_word(w_addr);
            pipe_id_q[0]   <= issued_q;
            if (abort_in) begin
                pipe_vld_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else if (abort_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({w_push, w_pop})
                2'b10:   fcnt_q <= fcnt_q + FCW'(1);
                2'b01:   fcnt_q <= fcnt_q - FCW'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push && !abort_in) begin
            fifo_tri[wr_ptr_q]  <= pipe_tri_q[ROM_LATENCY-1];
            fifo_id[wr_ptr_q]   <= pipe_id_q[ROM_LATENCY-1];
            fifo_last[wr_ptr_q] <= pipe_last_q[ROM_LATENCY-1];
        end
    end

    // Payload is forced to zero whenever nothing is being offered.
    assign tri_if.valid_out        = w_valid;
    assign tri_if.tri_vertices_out = w_valid ? fifo_tri[rd_ptr_q] : '0;
    assign tri_if.tri_id_out       = w_valid ? fifo_id[rd_ptr_q] : '0;
    assign tri_if.last_tri_out     = w_valid && fifo_last[rd_ptr_q];
    assign frame_done_out          = w_done;
    assign busy_out                = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tri_fetch_ranged.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_fetch_ranged
// Purpose  : Directed self-checking bench for tri_fetch_ranged
// Revision : 1.0
// ============================================================================
module tb_tri_fetch_ranged;
    localparam int COORD_WIDTH = 16;
    localparam int MAX_COUNT   = 2700;
    localparam int PAUSE_WIDTH = 16;
    localparam int AW          = $clog2(MAX_COUNT);
    localparam int CW          = $clog2(MAX_COUNT + 1);

    typedef logic [2:0][2:0][COORD_WIDTH-1:0] tri_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [AW-1:0]          base = '0;
    logic [CW-1:0]          count = '0;
    logic                   loop_en = 1'b0;
    logic [PAUSE_WIDTH-1:0] pause = '0;
    logic                   abort = 1'b0;
    logic                   frame_done, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tri_fetch_ranged_if #(.COORD_WIDTH(COORD_WIDTH), .CW(CW)) tif ();

    tri_fetch_ranged #(
        .COORD_WIDTH(COORD_WIDTH), .MAX_COUNT(MAX_COUNT), .FIFO_DEPTH(4),
        .ROM_LATENCY(2), .PAUSE_WIDTH(PAUSE_WIDTH), .INIT_FILE("mesh.mem")
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_in(base),
        .count_in(count), .loop_in(loop_en), .pause_cycles_in(pause),
        .abort_in(abort), .tri_if(tif), .frame_done_out(frame_done), .busy_out(busy)
    );

    // Mesh image: coordinate k of vertex v at ROM index a holds a*9+v*3+k.
    function automatic tri_t exp_tri(input int a);
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < 3; k++)
                t[v][k] = COORD_WIDTH'(a * 9 + v * 3 + k);
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int b, input int n, input logic lp, input int p);
        base    = AW'(b);
        count   = CW'(n);
        loop_en = lp;
        pause   = PAUSE_WIDTH'(p);
        start   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tif.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        checks++; if (tif.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tif.valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (tif.last_tri_out !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", tif.last_tri_out); end
        checks++; if (tif.tri_id_out !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", tif.tri_id_out); end
        checks++; if (tif.tri_vertices_out !== '0) begin errors++; $display("FAIL reset_vert: got %h want 0", tif.tri_vertices_out); end
    endtask

    task automatic test_basic;
        logic ev;
        tif.ready_in = 1'b1;
        launch(0, 8, 1'b0, 0);
        for (int c = 0; c <= 14; c++) begin
            ev = (c >= 4) && (c <= 11);
            checks++; if (tif.valid_out !== ev) begin errors++; $display("FAIL basic_valid c%0d: got %b want %b", c, tif.valid_out, ev); end
            if (ev) begin
                checks++; if (tif.tri_id_out !== CW'(c - 4)) begin errors++; $display("FAIL basic_id c%0d: got %0d want %0d", c, tif.tri_id_out, c - 4); end
                checks++; if (tif.tri_vertices_out !== exp_tri(c - 4)) begin errors++; $display("FAIL basic_vert c%0d: got %h want %h", c, tif.tri_vertices_out, exp_tri(c - 4)); end
            end
            checks++; if (tif.last_tri_out !== (c == 11)) begin errors++; $display("FAIL basic_last c%0d: got %b want %b", c, tif.last_tri_out, c == 11); end
            checks++; if (frame_done !== (c == 12)) begin errors++; $display("FAIL basic_done c%0d: got %b want %b", c, frame_done, c == 12); end
            checks++; if (busy !== (c >= 1 && c <= 12)) begin errors++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy, c >= 1 && c <= 12); end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int hs = 0, dn = 0;
        logic prev_stall = 1'b0;
        logic [CW-1:0] prev_id = '0;
        tri_t prev_tri = '0;
        logic r;
        launch(100, 16, 1'b0, 0);
        for (int c = 0; c < 200; c++) begin
            r = 1'($urandom_range(0, 1));
            tif.ready_in = r;
            if (prev_stall) begin
                checks++;
                if (tif.valid_out !== 1'b1 || tif.tri_id_out !== prev_id || tif.tri_vertices_out !== prev_tri) begin
                    errors++; $display("FAIL bp_stable c%0d: got v=%b id=%0d want v=1 id=%0d", c, tif.valid_out, tif.tri_id_out, prev_id);
                end
            end
            if (tif.valid_out === 1'b1) begin
                checks++; if (tif.tri_id_out !== CW'(hs)) begin errors++; $display("FAIL bp_id c%0d: got %0d want %0d", c, tif.tri_id_out, hs); end
                checks++; if (tif.tri_vertices_out !== exp_tri(100 + hs)) begin errors++; $display("FAIL bp_vert c%0d: got %h want %h", c, tif.tri_vertices_out, exp_tri(100 + hs)); end
                checks++; if (tif.last_tri_out !== (hs == 15)) begin errors++; $display("FAIL bp_last c%0d: got %b want %b", c, tif.last_tri_out, hs == 15); end
                if (r) hs++;
            end
            if (frame_done === 1'b1) dn++;
            prev_stall = (tif.valid_out === 1'b1) && !r;
            prev_id    = tif.tri_id_out;
            prev_tri   = tif.tri_vertices_out;
            tick();
            start = 1'b0;
        end
        checks++; if (hs != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", hs); end
        checks++; if (dn != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", dn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
    endtask

    task automatic test_tail;
        int hs = 0, dn = 0, vs = 0;
        tif.ready_in = 1'b1;
        launch(MAX_COUNT - 3, 10, 1'b0, 0);
        for (int c = 0; c <= 12; c++) begin
            if (tif.valid_out === 1'b1) begin
                checks++; if (tif.tri_id_out !== CW'(hs)) begin errors++; $display("FAIL tail_id c%0d: got %0d want %0d", c, tif.tri_id_out, hs); end
                checks++; if (tif.tri_vertices_out !== exp_tri(MAX_COUNT - 3 + hs)) begin errors++; $display("FAIL tail_vert c%0d: got %h want %h", c, tif.tri_vertices_out, exp_tri(MAX_COUNT - 3 + hs)); end
                checks++; if (tif.last_tri_out !== (hs == 2)) begin errors++; $display("FAIL tail_last c%0d: got %b want %b", c, tif.last_tri_out, hs == 2); end
                hs++;
            end
            if (frame_done === 1'b1) dn++;
            tick();
            start = 1'b0;
        end
        checks++; if (hs != 3) begin errors++; $display("FAIL tail_count: got %0d want 3", hs); end
        checks++; if (dn != 1) begin errors++; $display("FAIL tail_done: got %0d want 1", dn); end
        dn = 0;
        launch(MAX_COUNT, 5, 1'b0, 0);
        for (int c = 0; c <= 6; c++) begin
            if (tif.valid_out === 1'b1) vs++;
            if (frame_done === 1'b1) dn++;
            checks++; if (frame_done !== (c == 1)) begin errors++; $display("FAIL empty_done c%0d: got %b want %b", c, frame_done, c == 1); end
            tick();
            start = 1'b0;
        end
        checks++; if (vs != 0) begin errors++; $display("FAIL empty_valids: got %0d want 0", vs); end
        checks++; if (dn != 1) begin errors++; $display("FAIL empty_done_count: got %0d want 1", dn); end
    endtask

    task automatic test_loop;
        int hs = 0, dn = 0, last_c = -1;
        tif.ready_in = 1'b1;
        launch(50, 4, 1'b1, 10);
        for (int c = 0; c <= 50; c++) begin
            if (tif.valid_out === 1'b1) begin
                checks++; if (tif.tri_id_out !== CW'(hs % 4)) begin errors++; $display("FAIL loop_id c%0d: got %0d want %0d", c, tif.tri_id_out, hs % 4); end
                checks++; if (tif.tri_vertices_out !== exp_tri(50 + hs % 4)) begin errors++; $display("FAIL loop_vert c%0d: got %h want %h", c, tif.tri_vertices_out, exp_tri(50 + hs % 4)); end
                checks++; if (tif.last_tri_out !== (hs % 4 == 3)) begin errors++; $display("FAIL loop_last c%0d: got %b want %b", c, tif.last_tri_out, hs % 4 == 3); end
                // 10 idle cycles, then the 3-cycle issue-to-valid latency.
                if (hs > 0 && hs % 4 == 0) begin
                    checks++; if (c - last_c != 14) begin errors++; $display("FAIL loop_gap c%0d: got %0d want 14", c, c - last_c); end
                end
                last_c = c;
                hs++;
            end
            if (frame_done === 1'b1) begin
                dn++;
                checks++; if (c != last_c + 1) begin errors++; $display("FAIL loop_done_time c%0d: got %0d want %0d", c, c, last_c + 1); end
            end
            tick();
            start = 1'b0;
        end
        checks++; if (hs != 12) begin errors++; $display("FAIL loop_count: got %0d want 12", hs); end
        checks++; if (dn != 3) begin errors++; $display("FAIL loop_done_count: got %0d want 3", dn); end
        abort = 1'b1;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL loop_abort_done: got %b want 0", frame_done); end
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_abort_busy: got %b want 0", busy); end
        repeat (6) tick();
        checks++; if (tif.valid_out !== 1'b0) begin errors++; $display("FAIL loop_abort_valid: got %b want 0", tif.valid_out); end
    endtask

    task automatic test_abort;
        int vs = 0, hs = 0;
        tif.ready_in = 1'b0;
        launch(200, 20, 1'b0, 0);
        tick();
        start = 1'b0;
        repeat (7) tick();
        checks++; if (tif.valid_out !== 1'b1 || tif.tri_id_out !== '0) begin errors++; $display("FAIL abort_pre: got v=%b id=%0d want v=1 id=0", tif.valid_out, tif.tri_id_out); end
        abort = 1'b1;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", frame_done); end
        tick();
        abort = 1'b0;
        checks++; if (tif.valid_out !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", tif.valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        tif.ready_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (tif.valid_out === 1'b1) vs++;
            tick();
        end
        checks++; if (vs != 0) begin errors++; $display("FAIL abort_stale: got %0d valids want 0", vs); end
        launch(300, 3, 1'b0, 0);
        for (int c = 0; c <= 8; c++) begin
            if (tif.valid_out === 1'b1) begin
                checks++; if (tif.tri_id_out !== CW'(hs)) begin errors++; $display("FAIL abort_new_id c%0d: got %0d want %0d", c, tif.tri_id_out, hs); end
                checks++; if (tif.tri_vertices_out !== exp_tri(300 + hs)) begin errors++; $display("FAIL abort_new_vert c%0d: got %h want %h", c, tif.tri_vertices_out, exp_tri(300 + hs)); end
                hs++;
            end
            tick();
            start = 1'b0;
        end
        checks++; if (hs != 3) begin errors++; $display("FAIL abort_new_count: got %0d want 3", hs); end
    endtask

    task automatic test_async_reset;
        tif.ready_in = 1'b1;
        launch(10, 20, 1'b0, 0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++; if (tif.valid_out !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", tif.valid_out); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tif.valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", tif.valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (tif.tri_id_out !== '0 || tif.tri_vertices_out !== '0 || tif.last_tri_out !== 1'b0) begin
            errors++; $display("FAIL arst_data: got id=%0d last=%b want 0", tif.tri_id_out, tif.last_tri_out);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        launch(5, 2, 1'b0, 0);
        for (int c = 0; c <= 6; c++) begin
            checks++; if (tif.valid_out !== (c == 4 || c == 5)) begin errors++; $display("FAIL arst_new_valid c%0d: got %b want %b", c, tif.valid_out, c == 4 || c == 5); end
            if (c == 4 || c == 5) begin
                checks++; if (tif.tri_id_out !== CW'(c - 4) || tif.tri_vertices_out !== exp_tri(5 + c - 4)) begin
                    errors++; $display("FAIL arst_new_data c%0d: got id=%0d want %0d", c, tif.tri_id_out, c - 4);
                end
            end
            checks++; if (frame_done !== (c == 6)) begin errors++; $display("FAIL arst_new_done c%0d: got %b want %b", c, frame_done, c == 6); end
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tif.ready_in = 1'b0;
        test_reset();
        test_basic();
        repeat (3) tick();
        test_backpressure();
        repeat (3) tick();
        test_tail();
        repeat (3) tick();
        test_loop();
        repeat (3) tick();
        test_abort();
        repeat (3) tick();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
